// File: rtl/multiciclo_memory_interface_if.sv
// -----------------------------------------------------------------------------
// multiciclo_memory_interface_if
//   Unified instruction/data memory bus between the multicycle memory
//   interface (master) and the variable-latency memory (slave).
//
//   mem_req    master -> slave  access request, held until mem_ready
//   mem_we     master -> slave  1 = write, 0 = read
//   mem_addr   master -> slave  word-aligned byte address (low 2 bits are 0)
//   mem_be     master -> slave  byte enables, bit i covers bits 8i+7..8i
//   mem_wdata  master -> slave  lane-replicated store data
//   mem_ready  slave -> master  write accepted / read data valid
//   mem_rdata  slave -> master  read word
// -----------------------------------------------------------------------------
interface multiciclo_memory_interface_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/multiciclo_memory_interface.sv
// -----------------------------------------------------------------------------
// multiciclo_memory_interface
//   Turns the multicycle control unit's ReadMemory/WriteMemory strobes into a
//   single word-aligned bus transaction with byte enables, waits out a
//   variable-latency memory, and returns sign/zero-extended load data.
//   The control FSM holds its state until MemoryDone pulses.
//
//   clock, reset_n     system clock (rising edge), asynchronous active-low reset
//   ReadMemory         read request strobe
//   WriteMemory        write request strobe (wins when both are high)
//   InstructionFetch   forces a 32-bit access, funct3 ignored
//   funct3             access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   Address            byte address of the access
//   WriteData          store data (rs2)
//   ReadData           extended load result, held until the next good read
//   MemoryDone         one-cycle completion pulse (success or error)
//   MisalignedError    one-cycle pulse with MemoryDone on a misaligned access
//   BusError           one-cycle pulse with MemoryDone on a bus timeout
//   Busy               high whenever an access is in progress
//   bus                memory bus, master side
// -----------------------------------------------------------------------------
module multiciclo_memory_interface #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          ReadMemory,
    input  logic                          WriteMemory,
    input  logic                          InstructionFetch,
    input  logic [2:0]                    funct3,
    input  logic [ADDR_WIDTH-1:0]         Address,
    input  logic [31:0]                   WriteData,
    output logic [31:0]                   ReadData,
    output logic                          MemoryDone,
    output logic                          MisalignedError,
    output logic                          BusError,
    output logic                          Busy,
    multiciclo_memory_interface_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_t;

    // The counter only has to reach TIMEOUT_CYCLES-1: the cycle that would
    // make it equal to TIMEOUT_CYCLES is the one that aborts instead.
    localparam int CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [2:0]            f3_q,     f3_d;
    logic [31:0]           wdata_q,  wdata_d;
    logic                  ifetch_q, ifetch_d;
    logic                  write_q,  write_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [31:0]           rdata_q,  rdata_d;
    logic                  mis_q,    mis_d;
    logic                  buserr_q, buserr_d;

    size_t       size;
    logic [1:0]  offset;
    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        in_wait;

    // ------------------------------------------------------------------
    // Access decode from the values latched in IDLE
    // ------------------------------------------------------------------
    assign offset = addr_q[1:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        size       = SZ_WORD;
        misaligned = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = wdata_q;

        if (!ifetch_q) begin
            case (f3_q[1:0])
                2'b00:   size = SZ_BYTE;
                2'b01:   size = SZ_HALF;
                2'b10:   size = SZ_WORD;
                default: size = SZ_BAD;
            endcase
        end

        case (size)
            SZ_BYTE: begin
                be_c    = 4'b0001 << offset;
                wdata_c = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                misaligned = offset[0];
                be_c       = offset[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{wdata_q[15:0]}};
            end
            SZ_WORD: begin
                misaligned = (offset != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction and extension from the returned word
    // ------------------------------------------------------------------
    always_comb begin
        byte_lane = bus.mem_rdata[7:0];
        case (offset)
            2'd1:    byte_lane = bus.mem_rdata[15:8];
            2'd2:    byte_lane = bus.mem_rdata[23:16];
            2'd3:    byte_lane = bus.mem_rdata[31:24];
            default: byte_lane = bus.mem_rdata[7:0];
        endcase
        half_lane = offset[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (size)
            SZ_BYTE: load_c = f3_q[2] ? {24'h0, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_c = f3_q[2] ? {16'h0, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
            default: load_c = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        f3_d     = f3_q;
        wdata_d  = wdata_q;
        ifetch_d = ifetch_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        buserr_d = buserr_q;

        case (state_q)
            S_IDLE: begin
                if (ReadMemory || WriteMemory) begin
                    addr_d   = Address;
                    f3_d     = funct3;
                    wdata_d  = WriteData;
                    ifetch_d = InstructionFetch;
                    write_d  = WriteMemory;
                    mis_d    = 1'b0;
                    buserr_d = 1'b0;
                    state_d  = S_CHECK;
                end
            end

            S_CHECK: begin
                if (misaligned) begin
                    mis_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.mem_ready) begin
                    if (!write_q) begin
                        rdata_d = load_c;
                    end
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    buserr_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                // Strobes are not looked at here, so a strobe the control
                // still holds during this cycle cannot restart an access.
                mis_d    = 1'b0;
                buserr_d = 1'b0;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            f3_q     <= '0;
            wdata_q  <= '0;
            ifetch_q <= 1'b0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values of the previous cycle, regardless of statement order.
            state_q  <= state_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            wdata_q  <= wdata_d;
            ifetch_q <= ifetch_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            buserr_q <= buserr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded straight from registers, so an asynchronous reset
    // drops mem_req in the same cycle and no MemoryDone can follow.
    // ------------------------------------------------------------------
    assign in_wait = (state_q == S_WAIT);

    assign bus.mem_req   = in_wait;
    assign bus.mem_we    = in_wait & write_q;
    assign bus.mem_addr  = in_wait ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_be    = in_wait ? be_c : 4'b0000;
    assign bus.mem_wdata = in_wait ? wdata_c : 32'h0;

    assign ReadData        = rdata_q;
    assign MemoryDone      = (state_q == S_DONE);
    assign MisalignedError = (state_q == S_DONE) & mis_q;
    assign BusError        = (state_q == S_DONE) & buserr_q;
    assign Busy            = (state_q != S_IDLE);

endmodule

// File: doc/multiciclo_memory_interface.md
Name: multiciclo_memory_interface

Overview:
- Sits directly downstream of the multicycle control unit and between the datapath and the unified instruction/data memory bus.
- Converts the control's ReadMemory/WriteMemory strobes, the selected address and funct3 into a word-aligned bus transaction with byte enables.
- Waits out a variable-latency memory through a req/ready handshake, then returns sign- or zero-extended load data.
- Reports completion, misalignment and bus timeout back to the control FSM, which holds its state until MemoryDone.

Parameters:
- ADDR_WIDTH, 32, byte-address width; the bus address is word aligned, so its low 2 bits are always 0.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for mem_ready before abort; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ReadMemory  in  1  control requests a read access
- WriteMemory  in  1  control requests a write access
- InstructionFetch  in  1  forces a 32-bit access and ignores funct3 (used in the FETCH state)
- funct3  in  3  access size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000, 001 and 010
- Address  in  ADDR_WIDTH  byte address selected by MemoryAddressOrigin
- WriteData  in  32  rs2 value for stores
- ReadData  out  32  extended load result, held until the next access completes
- MemoryDone  out  1  one-cycle pulse when the access ends, on success or on error
- MisalignedError  out  1  one-cycle pulse, coincident with MemoryDone
- BusError  out  1  one-cycle pulse on timeout, coincident with MemoryDone
- Busy  out  1  high while the state is not IDLE
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_WIDTH  word-aligned bus address
- mem_be  out  4  byte enables; bit i selects bits 8i+7..8i
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory has accepted the access (writes) or rdata is valid (reads)
- mem_rdata  in  32  read word

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0, including ReadData; timeout counter 0. A reset asserted mid-transaction drops mem_req immediately, with no MemoryDone pulse.
- States:
  - IDLE: on a cycle with ReadMemory or WriteMemory high, latch Address, funct3, WriteData, InstructionFetch and the access type. If both strobes are high, the write takes priority. Go to CHECK.
  - CHECK: evaluate alignment. A misaligned access goes to DONE with the error flagged and no bus activity. An aligned access drives the bus outputs and goes to WAIT.
  - WAIT: mem_req is high; mem_addr, mem_we, mem_be and mem_wdata are stable. On a cycle with mem_ready high, latch the extended mem_rdata into ReadData (reads only) and go to DONE. Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, drop the request, flag BusError and go to DONE.
  - DONE: pulse MemoryDone plus any error flag for exactly one cycle, then return to IDLE. Strobes seen in DONE are ignored.
- mem_req falls in the cycle after ready is sampled. Minimum latency from strobe to MemoryDone is 3 cycles (IDLE→CHECK→WAIT with ready already high→DONE).
- Size: InstructionFetch set means word. Otherwise funct3[1:0] selects the size: 00 byte, 01 half, 10 word. funct3[2]=1 means zero-extend. funct3[1:0]=11 is treated as a misaligned access.
- Misaligned cases: half with addr[0]=1; word with addr[1:0]≠00.
- Byte enables, with offset o = addr[1:0]:
  - byte: mem_be = 1<<o
  - half: 0011 when o=00, 1100 when o=10
  - word: 1111
  - Reads drive the same mem_be values.
- Store data lanes:
  - byte: WriteData[7:0] replicated to all four lanes.
  - half: WriteData[15:0] replicated to both halves.
  - word: passed through unchanged.
- Load extraction: select the byte or half at the offset and sign-extend, unless funct3[2]=1, in which case zero-extend.
- ReadData is unchanged by writes, misaligned accesses and timeouts.
- Counter: clears on entry to WAIT. With TIMEOUT_CYCLES=0, WAIT lasts indefinitely.
- mem_ready high outside WAIT is ignored.

Test Plan:
- Reset mid-WAIT: assert reset_n=0 while mem_req=1 → mem_req=0 in the same cycle; all outputs 0; no MemoryDone pulse.
- LB at 0x1003 with mem_rdata=0x80FF_1234 and ready after 2 wait cycles → mem_addr=0x1000, mem_be=1000, ReadData=0xFFFF_FF80, one MemoryDone pulse.
- SH at 0x2002 with WriteData=0xDEAD_BEEF → mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF; ReadData keeps its previous value.
- LW at 0x3001 → MisalignedError and MemoryDone both pulse; mem_req never goes high.
- TIMEOUT_CYCLES=4 with mem_ready held at 0 → mem_req high for 4 cycles then dropped; BusError and MemoryDone pulse together.
- InstructionFetch=1 with funct3=000 at 0x0 and mem_rdata=0x0000_0513 → mem_be=1111, ReadData=0x0000_0513; a ReadMemory strobe held through DONE does not start a second access.
